// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with occupancy flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN to build first-word-fall-through mode; the default build uses a registered read.
module fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Flags come only from the registered count, never from the request inputs.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    // Storage is never cleared; reset only discards the words logically.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && !rd_accept;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is exposed directly; an accepted read moves rd_ptr and so the next word appears.
    assign data_out = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_accept) begin
            data_out <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (DEPTH=4): directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model. Honours FIFO_FWFT_EN when defined.
module tb_fifo_param;

    localparam int DW = 8;
    localparam int DEPTH = 4;
`ifdef FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_unf;
    bit            model_valid = 1'b0;

    fifo_param #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .AF_LEVEL(3),
        .AE_LEVEL(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .data_in(data_in),
        .data_out(data_out),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, return just after the rising edge.
    task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        @(negedge clk);
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Model: a plain queue; reads pop before writes push so a full FIFO can swap a word.
    always @(posedge clk) begin
        bit rd_ok;
        bit wr_ok;
        logic [DW-1:0] popped;
        if (rst) begin
            mq.delete();
            m_dout = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            rd_ok = rd_en && (mq.size() > 0);
            wr_ok = wr_en && ((mq.size() < DEPTH) || rd_ok);
            if (rd_ok) begin
                popped = mq.pop_front();
                if (!FWFT) m_dout = popped;
            end
            if (wr_ok) mq.push_back(data_in);
            if (FWFT) m_dout = (mq.size() > 0) ? mq[0] : '0;
            m_ovf = wr_en && !wr_ok;
            m_unf = rd_en && !rd_ok;
        end
    end

    // Compare process: every outputs-stable point once the model has seen a reset.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("data_out", 32'(data_out), 32'(m_dout));
            checkOutput("count", 32'(count), 32'(mq.size()));
            checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
            checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
            checkOutput("almost_full", 32'(almost_full), 32'(mq.size() >= 3));
            checkOutput("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("underflow", 32'(underflow), 32'(m_unf));
        end
    end

    initial begin
        logic [DW-1:0] wvals [4];
        int wprob;
        int rprob;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        wvals[0] = 8'h11; wvals[1] = 8'h22; wvals[2] = 8'h33; wvals[3] = 8'h44;

        $display("[TB] directed phase");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_ae", 32'(almost_empty), 32'd1);
        checkOutput("rst_dout", 32'(data_out), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rst_nowrite", 32'(count), 32'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, wvals[i]);
            checkOutput("fill_count", 32'(count), 32'(i + 1));
            checkOutput("fill_ae", 32'(almost_empty), 32'(i == 0));
            checkOutput("fill_af", 32'(almost_full), 32'(i >= 2));
            checkOutput("fill_full", 32'(full), 32'(i == 3));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h55);
        checkOutput("ovf_pulse", 32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            if (i == 0) checkOutput("ovf_drop", 32'(overflow), 32'd0);
            checkOutput("drain_dout", 32'(data_out),
                        FWFT ? ((i < 3) ? 32'(wvals[i+1]) : 32'h0) : 32'(wvals[i]));
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);

        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("unf_pulse", 32'(underflow), 32'd1);
        checkOutput("unf_dout", 32'(data_out), FWFT ? 32'h0 : 32'h44);
        checkOutput("unf_count", 32'(count), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
        checkOutput("emptyrw_count", 32'(count), 32'd1);
        checkOutput("emptyrw_unf", 32'(underflow), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("emptyrw_read", 32'(data_out), FWFT ? 32'h0 : 32'h77);
        checkOutput("unf_drop", 32'(underflow), 32'd0);

        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, DW'(i));
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h66);
        checkOutput("fullrw_dout", 32'(data_out), FWFT ? 32'h02 : 32'h01);
        checkOutput("fullrw_count", 32'(count), 32'd4);
        checkOutput("fullrw_ovf", 32'(overflow), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("wrap_penult", 32'(data_out), FWFT ? 32'h66 : 32'h04);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("wrap_last", 32'(data_out), FWFT ? 32'h0 : 32'h66);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("fwft_show", 32'(data_out), FWFT ? 32'hA5 : 32'h66);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("fwft_empty", 32'(empty), 32'd1);
        checkOutput("fwft_read", 32'(data_out), FWFT ? 32'h0 : 32'hA5);

        $display("[TB] random phase");
        for (int c = 0; c < 3000; c++) begin
            case ((c / 250) % 3)
                0:       begin wprob = 80; rprob = 30; end
                1:       begin wprob = 50; rprob = 50; end
                default: begin wprob = 20; rprob = 80; end
            endcase
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 99) < wprob,
                          $urandom_range(0, 99) < rprob,
                          DW'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
